// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 5-stage MIPS pipeline. Word-wide data RAM access,
// MEM/WB pipeline register, write-back data mux and a sticky memory-fault flag.
`default_nettype none

module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wdi,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] w_index;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_fault;
  logic              w_store;

  logic [31:0] wmo_q,    wmo_d;
  logic [31:0] walu_q,   walu_d;
  logic [4:0]  wrn_q,    wrn_d;
  logic        wwreg_q,  wwreg_d;
  logic        wm2reg_q, wm2reg_d;
  logic        err_q,    err_d;

  assign w_index      = malu[ADDR_W+1:2];
  assign w_misaligned = (malu[1:0] != 2'b00);

  generate
    if (ADDR_W < 30) begin : g_range_chk
      assign w_out_of_range = |malu[31:ADDR_W+2];
    end else begin : g_full_range
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_fault = (mwmem | mm2reg) & (w_misaligned | w_out_of_range);
  assign w_store = mwmem & ~w_fault;

  // RAM is never reset; the rst_n term only blocks a store on the edge reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_store) begin
      mem_q[w_index] <= mb;
    end
  end

  always_comb begin
    wmo_d    = 32'h0;
    walu_d   = malu;
    wrn_d    = mrn;
    wm2reg_d = mm2reg;
    wwreg_d  = mwreg & ~(mm2reg & w_fault);
    err_d    = err_q | w_fault;
    if (mm2reg && !w_fault) begin
      wmo_d = mem_q[w_index];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmo_q    <= 32'h0;
      walu_q   <= 32'h0;
      wrn_q    <= 5'h0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wmo_q    <= wmo_d;
      walu_q   <= walu_d;
      wrn_q    <= wrn_d;
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      err_q    <= err_d;
    end
  end

  assign wmo     = wmo_q;
  assign walu    = walu_q;
  assign wrn     = wrn_q;
  assign wwreg   = wwreg_q;
  assign wm2reg  = wm2reg_q;
  assign mem_err = err_q;
  assign wdi     = wm2reg_q ? wmo_q : walu_q;

endmodule

`default_nettype wire
